// File: rtl/hs32_wbarb_pkg.sv
// hs32_wbarb_pkg: shared types for the HS32 write-back arbiter
package hs32_wbarb_pkg;
    localparam int HS32_NREGS = 16;

    typedef struct packed {
        logic [3:0]  rd;
        logic [31:0] data;
    } hs32_wbpkt;

    typedef enum logic {NORM, DRAIN} hs32_wbarb_st;
endpackage

// File: rtl/hs32_wbfifo.sv
// hs32_wbfifo: pending ALU write buffer with per-entry valid, kill-by-address and newest-first lookup
module hs32_wbfifo
    import hs32_wbarb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push,
    input  hs32_wbpkt             push_pkt,
    input  logic                  pop,
    input  logic                  drain,
    input  logic                  kill,
    input  logic [3:0]            kill_rd,
    input  logic [3:0]            byp_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  any_vld,
    output logic                  wr_vld,
    output hs32_wbpkt             wr_pkt,
    output logic [HS32_NREGS-1:0] pend_mask,
    output logic                  hit,
    output logic [31:0]           hit_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    hs32_wbpkt        mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [AW-1:0]    rptr, wptr;
    logic [CW-1:0]    count, npop;
    logic             found;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign any_vld = |vld;

    always_comb begin
        pend_mask = '0;
        hit       = 1'b0;
        hit_data  = '0;
        npop      = '0;
        wr_vld    = 1'b0;
        wr_pkt    = mem[rptr];
        found     = 1'b0;
        for (int k = 0; k < DEPTH; k++)
            if (vld[k]) pend_mask[mem[k].rd] = 1'b1;
        // oldest to newest, so the newest match is the one left standing
        for (int k = 0; k < DEPTH; k++)
            if (vld[rptr + AW'(k)] && mem[rptr + AW'(k)].rd == byp_addr) begin
                hit      = 1'b1;
                hit_data = mem[rptr + AW'(k)].data;
            end
        if (pop) begin
            npop   = CW'(1);
            wr_vld = vld[rptr];
        end
        // a drain pops every killed entry ahead of the first live one in a single cycle
        if (drain) begin
            npop = count;
            for (int k = 0; k < DEPTH; k++)
                if (!found && vld[rptr + AW'(k)]) begin
                    found  = 1'b1;
                    npop   = CW'(k + 1);
                    wr_pkt = mem[rptr + AW'(k)];
                end
            wr_vld = found;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld   <= '0;
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (kill && vld[k] && mem[k].rd == kill_rd) vld[k] <= 1'b0;
                if (CW'(k) < npop) vld[rptr + AW'(k)] <= 1'b0;
            end
            if (push) vld[wptr] <= 1'b1;
            rptr  <= rptr + npop[AW-1:0];
            wptr  <= wptr + AW'(push);
            count <= count + CW'(push) - npop;
        end
    end

    always_ff @(posedge clk)
        if (push) mem[wptr] <= push_pkt;
endmodule

// File: rtl/hs32_wbarb.sv
// hs32_wbarb: arbitrates the single regfile write port between l2 loads and s3 ALU results
module hs32_wbarb
    import hs32_wbarb_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int MAXWAIT = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  alu_vld_i,
    input  logic [3:0]            alu_rd_i,
    input  logic [31:0]           alu_data_i,
    output logic                  alu_rdy_o,
    input  logic                  ld_vld_i,
    input  logic [3:0]            ld_rd_i,
    input  logic [31:0]           ld_data_i,
    output logic                  ld_rdy_o,
    output logic                  we_o,
    output logic [3:0]            wa_o,
    output logic [31:0]           wd_o,
    input  logic [3:0]            byp_addr_i,
    output logic                  byp_hit_o,
    output logic [31:0]           byp_data_o,
    output logic [HS32_NREGS-1:0] pend_mask_o
);
    localparam int WW = $clog2(MAXWAIT + 1);

    hs32_wbarb_st  state, nxt_state;
    logic [WW-1:0] wait_cnt, nxt_cnt;
    logic          full, empty, any_vld, wr_vld, f_hit, wb_hit;
    logic          drain, ld_go, pop, direct, push, nxt_we;
    logic [31:0]   f_data;
    hs32_wbpkt     wr_pkt, nxt_pkt;

    assign drain     = state == DRAIN;
    assign ld_rdy_o  = !drain;
    assign ld_go     = ld_vld_i && !drain;
    assign pop       = !drain && !ld_vld_i && !empty;
    assign direct    = !drain && !ld_vld_i && empty && alu_vld_i;
    assign alu_rdy_o = !full || pop || drain;
    assign push      = alu_vld_i && alu_rdy_o && !direct;
    assign nxt_we    = ld_go || direct || ((pop || drain) && wr_vld);
    assign nxt_pkt   = ld_go  ? hs32_wbpkt'{rd: ld_rd_i, data: ld_data_i} :
                       direct ? hs32_wbpkt'{rd: alu_rd_i, data: alu_data_i} : wr_pkt;

    hs32_wbfifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (push),
        .push_pkt (hs32_wbpkt'{rd: alu_rd_i, data: alu_data_i}),
        .pop      (pop),
        .drain    (drain),
        .kill     (ld_go),
        .kill_rd  (ld_rd_i),
        .byp_addr (byp_addr_i),
        .full     (full),
        .empty    (empty),
        .any_vld  (any_vld),
        .wr_vld   (wr_vld),
        .wr_pkt   (wr_pkt),
        .pend_mask(pend_mask_o),
        .hit      (f_hit),
        .hit_data (f_data)
    );

    assign wb_hit     = we_o && wa_o == byp_addr_i;
    assign byp_hit_o  = f_hit || wb_hit;
    assign byp_data_o = f_hit ? f_data : wb_hit ? wd_o : '0;

    // loads beating a live buffered entry MAXWAIT times in a row force one drain cycle
    always_comb begin
        nxt_state = state;
        nxt_cnt   = wait_cnt;
        if (drain) begin
            nxt_state = NORM;
            nxt_cnt   = '0;
        end else if (ld_go && any_vld) begin
            nxt_state = wait_cnt == WW'(MAXWAIT - 1) ? DRAIN : NORM;
            nxt_cnt   = wait_cnt == WW'(MAXWAIT - 1) ? '0 : wait_cnt + WW'(1);
        end else if (pop) begin
            nxt_cnt = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= NORM;
            wait_cnt <= '0;
            we_o     <= 1'b0;
            wa_o     <= '0;
            wd_o     <= '0;
        end else begin
            state    <= nxt_state;
            wait_cnt <= nxt_cnt;
            we_o     <= nxt_we;
            if (nxt_we) begin
                wa_o <= nxt_pkt.rd;
                wd_o <= nxt_pkt.data;
            end
        end
    end
endmodule

// File: tb/tb_hs32_wbarb.sv
// tb_hs32_wbarb: queue-based reference model with a write-port scoreboard
module tb_hs32_wbarb;
    localparam int DEPTH   = 2;
    localparam int MAXWAIT = 4;

    logic        clk = 1'b0, rstn = 1'b0;
    logic        alu_vld_i = 1'b0, ld_vld_i = 1'b1;
    logic [3:0]  alu_rd_i = '0, ld_rd_i = '0, byp_addr_i = '0;
    logic [31:0] alu_data_i = '0, ld_data_i = '0;
    logic        alu_rdy_o, ld_rdy_o, we_o, byp_hit_o;
    logic [3:0]  wa_o;
    logic [31:0] wd_o, byp_data_o;
    logic [15:0] pend_mask_o;

    hs32_wbarb #(.DEPTH(DEPTH), .MAXWAIT(MAXWAIT)) dut (
        .clk(clk), .rstn(rstn),
        .alu_vld_i(alu_vld_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i), .alu_rdy_o(alu_rdy_o),
        .ld_vld_i(ld_vld_i), .ld_rd_i(ld_rd_i), .ld_data_i(ld_data_i), .ld_rdy_o(ld_rdy_o),
        .we_o(we_o), .wa_o(wa_o), .wd_o(wd_o),
        .byp_addr_i(byp_addr_i), .byp_hit_o(byp_hit_o), .byp_data_o(byp_data_o),
        .pend_mask_o(pend_mask_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rd;
        logic [31:0] data;
        bit          live;
    } ent_t;

    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
    } wr_t;

    ent_t        pend[$];
    wr_t         exp_q[$];
    bit          m_drain = 0, m_we = 0;
    int          m_wait = 0;
    logic [3:0]  m_wa = '0;
    logic [31:0] m_wd = '0;
    int          checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        exp_q.delete();
        m_drain = 0;
        m_wait  = 0;
        m_we    = 0;
    endtask

    // apply one cycle of inputs, check the combinational view, then advance the model
    task automatic drive(input bit av, input logic [3:0] ar, input logic [31:0] ad,
                         input bit lv, input logic [3:0] lr, input logic [31:0] ld,
                         input logic [3:0] ba);
        logic [15:0] mask;
        bit          ehit, g, popped, direct, e_ardy, e_lrdy, had_live;
        logic [31:0] edata;
        int          size0;
        ent_t        e;
        wr_t         w;
        alu_vld_i = av; alu_rd_i = ar; alu_data_i = ad;
        ld_vld_i  = lv; ld_rd_i  = lr; ld_data_i  = ld;
        byp_addr_i = ba;
        #1;
        mask = '0;
        foreach (pend[i]) if (pend[i].live) mask[pend[i].rd] = 1'b1;
        ehit = 0;
        edata = '0;
        for (int i = pend.size() - 1; i >= 0; i--)
            if (pend[i].live && pend[i].rd == ba) begin
                ehit = 1;
                edata = pend[i].data;
                break;
            end
        if (!ehit && m_we && m_wa == ba) begin
            ehit = 1;
            edata = m_wd;
        end
        size0 = pend.size();
        had_live = mask != 0;
        e_lrdy = !m_drain;
        g = 0; popped = 0; direct = 0;
        w.a = '0; w.d = '0;
        if (m_drain) begin
            while (pend.size() > 0 && !pend[0].live) void'(pend.pop_front());
            if (pend.size() > 0) begin
                e = pend.pop_front();
                g = 1; w.a = e.rd; w.d = e.data;
            end
            popped = 1;
            m_drain = 0;
            m_wait = 0;
        end else if (lv) begin
            g = 1; w.a = lr; w.d = ld;
            foreach (pend[i]) if (pend[i].rd == lr) pend[i].live = 0;
            if (had_live) begin
                m_wait++;
                if (m_wait == MAXWAIT) begin
                    m_drain = 1;
                    m_wait = 0;
                end
            end
        end else if (size0 > 0) begin
            e = pend.pop_front();
            popped = 1;
            m_wait = 0;
            if (e.live) begin
                g = 1; w.a = e.rd; w.d = e.data;
            end
        end else if (av) begin
            g = 1; direct = 1; w.a = ar; w.d = ad;
        end
        e_ardy = size0 < DEPTH || popped;
        if (av && e_ardy && !direct) pend.push_back('{rd: ar, data: ad, live: 1'b1});
        chk("alu_rdy", 32'(alu_rdy_o), 32'(e_ardy));
        chk("ld_rdy", 32'(ld_rdy_o), 32'(e_lrdy));
        chk("pend_mask", 32'(pend_mask_o), 32'(mask));
        chk("byp_hit", 32'(byp_hit_o), 32'(ehit));
        chk("byp_data", byp_data_o, edata);
        if (g) exp_q.push_back(w);
        m_we = g; m_wa = w.a; m_wd = w.d;
    endtask

    task automatic idle(input logic [3:0] ba);
        drive(0, '0, '0, 0, '0, '0, ba);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        wr_t w;
        #2;
        if (rstn && we_o) begin
            if (exp_q.size() == 0) begin
                chk("wb_unexpected", 32'(wa_o), 32'hFFFF_FFFF);
            end else begin
                w = exp_q.pop_front();
                chk("wb_addr", 32'(wa_o), 32'(w.a));
                chk("wb_data", wd_o, w.d);
            end
        end
    end

    initial begin
        #2;
        chk("rst_we", 32'(we_o), 0);
        chk("rst_wa", 32'(wa_o), 0);
        chk("rst_wd", wd_o, 0);
        chk("rst_alu_rdy", 32'(alu_rdy_o), 1);
        chk("rst_ld_rdy", 32'(ld_rdy_o), 1);
        chk("rst_pend", 32'(pend_mask_o), 0);
        chk("rst_byp_hit", 32'(byp_hit_o), 0);
        repeat (2) @(negedge clk);
        chk("rst_we_held", 32'(we_o), 0);
        rstn = 1'b1;
        model_reset();

        drive(0, '0, '0, 1, 4'd3, 32'hAA, '0); step();
        idle('0);
        chk("first_we", 32'(we_o), 1);
        chk("first_wa", 32'(wa_o), 3);
        chk("first_wd", wd_o, 32'hAA);
        step();

        drive(1, 4'd5, 32'h11, 1, 4'd2, 32'h22, 4'd5); step();
        idle(4'd5);
        chk("sim_pend", 32'(pend_mask_o), 32'h0020);
        chk("sim_byp_hit", 32'(byp_hit_o), 1);
        chk("sim_byp_data", byp_data_o, 32'h11);
        step();
        idle('0); step();

        for (int i = 0; i < 6; i++) begin
            drive(1, i == 0 ? 4'd1 : i == 1 ? 4'd4 : 4'd9, 32'h100 + i,
                  1, 4'(10 + i), 32'h200 + i, '0);
            if (i == 2) chk("full_alu_rdy", 32'(alu_rdy_o), 0);
            if (i == 5) chk("starve_ld_rdy", 32'(ld_rdy_o), 0);
            step();
        end
        idle('0);
        chk("starve_ld_rdy_back", 32'(ld_rdy_o), 1);
        chk("starve_wa", 32'(wa_o), 1);
        step();
        repeat (3) begin idle('0); step(); end

        drive(1, 4'd7, 32'h5, 1, 4'd8, 32'h3, 4'd7); step();
        drive(0, '0, '0, 1, 4'd7, 32'h9, 4'd7);
        chk("kill_pre_byp", byp_data_o, 32'h5);
        step();
        idle(4'd7);
        chk("kill_pend", 32'(pend_mask_o), 0);
        chk("kill_byp_hit", 32'(byp_hit_o), 1);
        chk("kill_byp_data", byp_data_o, 32'h9);
        step();
        idle('0); step();

        drive(1, 4'd6, 32'h1, 1, 4'd8, 32'hA, '0); step();
        drive(1, 4'd6, 32'h2, 1, 4'd9, 32'hB, '0); step();
        idle(4'd6);
        chk("waw_byp_newest", byp_data_o, 32'h2);
        step();
        repeat (2) begin idle('0); step(); end

        drive(1, 4'd3, 32'h33, 1, 4'd10, 32'h1, '0); step();
        drive(1, 4'd4, 32'h44, 1, 4'd11, 32'h2, '0); step();
        alu_vld_i = 0; ld_vld_i = 0;
        #2 rstn = 1'b0;
        #1;
        chk("midrst_we", 32'(we_o), 0);
        chk("midrst_pend", 32'(pend_mask_o), 0);
        model_reset();
        step();
        rstn = 1'b1;
        repeat (4) begin idle('0); step(); end

        for (int n = 0; n < 1500; n++) begin
            drive($urandom_range(0, 9) < 6, 4'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 9) < 4, 4'($urandom_range(0, 7)), $urandom,
                  4'($urandom_range(0, 15)));
            step();
        end
        repeat (10) begin idle('0); step(); end
        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
